// File: rtl/br_lite_noc.sv
// Broadcast-lite mesh NoC: one flooding router per PE, duplicate suppression via a
// small seen-message table per router, with ALL/TGT delivery to the local PE.
package br_lite_noc_pkg;
  typedef enum logic {BR_SVC_TGT = 1'b0, BR_SVC_ALL = 1'b1} br_svc_e;

  typedef struct packed {
    logic [31:0] payload;
    logic [15:0] seq_source;
    logic [15:0] seq_target;
    br_svc_e     service;
    logic [4:0]  id;
  } br_data_t;
endpackage

module br_lite_noc_router
  import br_lite_noc_pkg::*;
#(
  parameter int         PE_IDX       = 0,
  parameter logic [3:0] LINK_EN      = 4'hF,
  parameter int         CAM_SIZE     = 8,
  parameter int         CLEAR_CYCLES = 256
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  br_data_t       inj_flit_i,
  input  logic           inj_req_i,
  output logic           inj_ack_o,
  output logic           busy_o,
  output br_data_t       dlv_flit_o,
  output logic           dlv_req_o,
  input  logic           dlv_ack_i,
  input  logic     [3:0] lnk_req_i,
  input  br_data_t [3:0] lnk_flit_i,
  output logic     [3:0] lnk_ack_o,
  output logic     [3:0] lnk_req_o,
  output br_data_t       lnk_flit_o,
  input  logic     [3:0] lnk_ack_i
);
  localparam int IW = (CAM_SIZE > 1) ? $clog2(CAM_SIZE) : 1;
  localparam int CW = $clog2(CAM_SIZE + 1);
  localparam int TW = $clog2(CLEAR_CYCLES + 1);

  typedef enum logic [1:0] {ENT_FREE, ENT_PEND, ENT_DONE} ent_e;
  typedef enum logic [1:0] {INJ_IDLE, INJ_ACK, INJ_WAIT} inj_e;

  ent_e          ent_state_q [CAM_SIZE];
  ent_e          ent_state_d [CAM_SIZE];
  br_data_t      ent_flit_q  [CAM_SIZE];
  br_data_t      ent_flit_d  [CAM_SIZE];
  logic [TW-1:0] ent_timer_q [CAM_SIZE];
  logic [TW-1:0] ent_timer_d [CAM_SIZE];
  logic [IW-1:0] fifo_q      [CAM_SIZE];
  logic [IW-1:0] fifo_d      [CAM_SIZE];
  logic [IW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] pend_cnt_q, pend_cnt_d;
  inj_e          inj_state_q, inj_state_d;
  logic [3:0]    lnk_ack_q, lnk_ack_d, lnk_req_q, lnk_req_d;
  logic          dlv_req_q, dlv_req_d, fwd_active_q, fwd_active_d;
  br_data_t      out_flit_q, out_flit_d;

  logic [CW-1:0] free_cnt;
  logic [IW-1:0] free_idx, head;
  logic          free_any, push, pop;
  logic [3:0]    lnk_dup;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(CAM_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic delivers(input br_data_t f);
    if (f.service == BR_SVC_ALL) return f.seq_source != 16'(PE_IDX);
    return f.seq_target == 16'(PE_IDX);
  endfunction

  // Free-slot search and duplicate lookup; any non-FREE entry counts as seen.
  always_comb begin
    free_cnt = '0;
    free_any = 1'b0;
    free_idx = '0;
    lnk_dup  = '0;
    for (int i = CAM_SIZE - 1; i >= 0; i--) begin
      if (ent_state_q[i] == ENT_FREE) begin
        free_cnt = free_cnt + 1'b1;
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < CAM_SIZE; i++) begin
        if (ent_state_q[i] != ENT_FREE &&
            ent_flit_q[i].seq_source == lnk_flit_i[d].seq_source &&
            ent_flit_q[i].id == lnk_flit_i[d].id) begin
          lnk_dup[d] = 1'b1;
        end
      end
    end
  end

  // The last FREE entry is held back for network traffic.
  assign busy_o = (free_cnt < CW'(2)) || (inj_state_q != INJ_IDLE);
  assign head   = fifo_q[rd_ptr_q];

  always_comb begin
    ent_state_d  = ent_state_q;
    ent_flit_d   = ent_flit_q;
    ent_timer_d  = ent_timer_q;
    fifo_d       = fifo_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    pend_cnt_d   = pend_cnt_q;
    inj_state_d  = inj_state_q;
    lnk_ack_d    = '0;
    lnk_req_d    = lnk_req_q;
    dlv_req_d    = dlv_req_q;
    fwd_active_d = fwd_active_q;
    out_flit_d   = out_flit_q;
    inj_ack_o    = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;

    for (int i = 0; i < CAM_SIZE; i++) begin
      if (ent_state_q[i] == ENT_DONE) begin
        if (ent_timer_q[i] >= TW'(CLEAR_CYCLES)) begin
          ent_state_d[i] = ENT_FREE;
          ent_timer_d[i] = '0;
        end else begin
          ent_timer_d[i] = ent_timer_q[i] + 1'b1;
        end
      end
    end

    unique case (inj_state_q)
      INJ_IDLE: begin
        if (inj_req_i && !busy_o) begin
          push                 = 1'b1;
          ent_flit_d[free_idx] = inj_flit_i;
          inj_state_d          = INJ_ACK;
        end
      end
      INJ_ACK: begin
        inj_ack_o   = 1'b1;
        inj_state_d = INJ_WAIT;
      end
      INJ_WAIT: if (!inj_req_i) inj_state_d = INJ_IDLE;
      default:  inj_state_d = INJ_IDLE;
    endcase

    // Skipping requests already acked last cycle avoids taking a held req twice.
    for (int d = 0; d < 4; d++) begin
      if (lnk_req_i[d] && !lnk_ack_q[d]) begin
        if (lnk_dup[d]) begin
          lnk_ack_d[d] = 1'b1;
        end else if (!push && free_any) begin
          push                 = 1'b1;
          ent_flit_d[free_idx] = lnk_flit_i[d];
          lnk_ack_d[d]         = 1'b1;
        end
      end
    end

    if (push) begin
      ent_state_d[free_idx] = ENT_PEND;
      fifo_d[wr_ptr_q]      = free_idx;
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end

    if (fwd_active_q) begin
      lnk_req_d = lnk_req_q & ~lnk_ack_i;
      dlv_req_d = dlv_req_q & ~dlv_ack_i;
      if (lnk_req_d == '0 && !dlv_req_d) begin
        pop               = 1'b1;
        fwd_active_d      = 1'b0;
        ent_state_d[head] = ENT_DONE;
        ent_timer_d[head] = '0;
        rd_ptr_d          = ptr_inc(rd_ptr_q);
      end
    end else if (pend_cnt_q != '0) begin
      fwd_active_d = 1'b1;
      out_flit_d   = ent_flit_q[head];
      lnk_req_d    = LINK_EN;
      dlv_req_d    = delivers(ent_flit_q[head]);
    end

    unique case ({push, pop})
      2'b10:   pend_cnt_d = pend_cnt_q + 1'b1;
      2'b01:   pend_cnt_d = pend_cnt_q - 1'b1;
      default: pend_cnt_d = pend_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < CAM_SIZE; i++) begin
        ent_state_q[i] <= ENT_FREE;
        ent_flit_q[i]  <= '0;
        ent_timer_q[i] <= '0;
        fifo_q[i]      <= '0;
      end
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      pend_cnt_q   <= '0;
      inj_state_q  <= INJ_IDLE;
      lnk_ack_q    <= '0;
      lnk_req_q    <= '0;
      dlv_req_q    <= 1'b0;
      fwd_active_q <= 1'b0;
      out_flit_q   <= '0;
    end else begin
      ent_state_q  <= ent_state_d;
      ent_flit_q   <= ent_flit_d;
      ent_timer_q  <= ent_timer_d;
      fifo_q       <= fifo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      pend_cnt_q   <= pend_cnt_d;
      inj_state_q  <= inj_state_d;
      lnk_ack_q    <= lnk_ack_d;
      lnk_req_q    <= lnk_req_d;
      dlv_req_q    <= dlv_req_d;
      fwd_active_q <= fwd_active_d;
      out_flit_q   <= out_flit_d;
    end
  end

  assign lnk_ack_o  = lnk_ack_q;
  assign lnk_req_o  = lnk_req_q;
  assign lnk_flit_o = out_flit_q;
  assign dlv_flit_o = out_flit_q;
  assign dlv_req_o  = dlv_req_q;
endmodule

module br_lite_noc
  import br_lite_noc_pkg::*;
#(
  parameter  int X_CNT        = 4,
  parameter  int Y_CNT        = 4,
  parameter  int CAM_SIZE     = 8,
  parameter  int CLEAR_CYCLES = 256,
  localparam int PE_CNT       = X_CNT * Y_CNT
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  br_data_t [PE_CNT-1:0]     flit_i,
  input  logic     [PE_CNT-1:0]     req_i,
  output logic     [PE_CNT-1:0]     ack_o,
  output br_data_t [PE_CNT-1:0]     flit_o,
  output logic     [PE_CNT-1:0]     req_o,
  input  logic     [PE_CNT-1:0]     ack_i,
  output logic     [PE_CNT-1:0]     busy_o
);
  // Port order per router: 0 = N (y-1), 1 = E (x+1), 2 = S (y+1), 3 = W (x-1).
  logic     [3:0] tx_req  [PE_CNT];
  logic     [3:0] tx_ack  [PE_CNT];
  br_data_t       tx_flit [PE_CNT];
  logic     [3:0] rx_req  [PE_CNT];
  logic     [3:0] rx_ack  [PE_CNT];
  br_data_t [3:0] rx_flit [PE_CNT];

  for (genvar gi = 0; gi < PE_CNT; gi++) begin : gen_node
    localparam int         GX      = gi % X_CNT;
    localparam int         GY      = gi / X_CNT;
    localparam logic [3:0] LINK_EN = {GX > 0, GY < Y_CNT - 1, GX < X_CNT - 1, GY > 0};

    for (genvar gd = 0; gd < 4; gd++) begin : gen_port
      localparam int NB  = (gd == 0) ? gi - X_CNT : (gd == 1) ? gi + 1 :
                           (gd == 2) ? gi + X_CNT : gi - 1;
      localparam int OPP = (gd + 2) % 4;
      if (LINK_EN[gd]) begin : gen_link
        assign rx_req[gi][gd]  = tx_req[NB][OPP];
        assign rx_flit[gi][gd] = tx_flit[NB];
        assign tx_ack[gi][gd]  = rx_ack[NB][OPP];
      end else begin : gen_edge
        // Mesh edge loops back on itself; LINK_EN keeps this req low so it stays idle.
        assign rx_req[gi][gd]  = tx_req[gi][gd];
        assign rx_flit[gi][gd] = tx_flit[gi];
        assign tx_ack[gi][gd]  = rx_ack[gi][gd];
      end
    end

    br_lite_noc_router #(
      .PE_IDX      (gi),
      .LINK_EN     (LINK_EN),
      .CAM_SIZE    (CAM_SIZE),
      .CLEAR_CYCLES(CLEAR_CYCLES)
    ) u_router (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .inj_flit_i(flit_i[gi]),
      .inj_req_i (req_i[gi]),
      .inj_ack_o (ack_o[gi]),
      .busy_o    (busy_o[gi]),
      .dlv_flit_o(flit_o[gi]),
      .dlv_req_o (req_o[gi]),
      .dlv_ack_i (ack_i[gi]),
      .lnk_req_i (rx_req[gi]),
      .lnk_flit_i(rx_flit[gi]),
      .lnk_ack_o (rx_ack[gi]),
      .lnk_req_o (tx_req[gi]),
      .lnk_flit_o(tx_flit[gi]),
      .lnk_ack_i (tx_ack[gi])
    );
  end
endmodule

// File: tb/tb_br_lite_noc.sv
// Directed bench for br_lite_noc: a delivery model (who must receive which message, once)
// checked on every cycle by one monitor, plus literal per-scenario delivery counts.
module tb_br_lite_noc;
  import br_lite_noc_pkg::*;

  localparam int PE = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  br_data_t [PE-1:0]     flit_i, flit_o;
  logic     [PE-1:0]     req_i, ack_o, req_o, ack_i, busy_o;

  br_lite_noc #(.X_CNT(4), .Y_CNT(4), .CAM_SIZE(8), .CLEAR_CYCLES(256)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .flit_i(flit_i),
    .req_i (req_i),
    .ack_o (ack_o),
    .flit_o(flit_o),
    .req_o (req_o),
    .ack_i (ack_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int       checks = 0;
  int       errors = 0;
  int       deliv_cnt = 0;
  int       last_pe = -1;
  bit       exp_pend [PE][PE][32];
  br_data_t msg_tab  [PE][32];
  br_data_t held     [PE];
  int       ack_delay[PE];
  int       wait_cnt [PE];
  bit       ack_prev [PE];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Delivery monitor and PE-side acknowledger.
  initial begin
    ack_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ack_i = '0;
        for (int p = 0; p < PE; p++) begin
          wait_cnt[p] = 0;
          ack_prev[p] = 1'b0;
        end
      end else begin
        for (int p = 0; p < PE; p++) begin
          if (ack_prev[p]) begin
            chk("req_drop", req_o[p], 1'b0);
            ack_i[p]    = 1'b0;
            ack_prev[p] = 1'b0;
            wait_cnt[p] = 0;
          end else if (req_o[p]) begin
            if (wait_cnt[p] == 0) begin
              int s;
              int id;
              bit ok;
              s  = int'(flit_o[p].seq_source);
              id = int'(flit_o[p].id);
              ok = (s < PE) ? exp_pend[p][s][id] : 1'b0;
              deliv_cnt++;
              last_pe = p;
              $display("deliver pe=%0d src=%0d tgt=%0d id=%0d payload=%h", p, s,
                       flit_o[p].seq_target, id, flit_o[p].payload);
              chk("deliver_expected", ok, 1'b1);
              if (ok) begin
                chk("deliver_flit", flit_o[p], msg_tab[s][id]);
                exp_pend[p][s][id] = 1'b0;
              end
              held[p] = flit_o[p];
            end else begin
              chk("flit_stable", flit_o[p], held[p]);
            end
            wait_cnt[p]++;
            if (wait_cnt[p] > ack_delay[p]) begin
              ack_i[p]    = 1'b1;
              ack_prev[p] = 1'b1;
            end
          end else if (wait_cnt[p] > 0) begin
            chk("req_held", req_o[p], 1'b1);
            wait_cnt[p] = 0;
          end
        end
      end
    end
  end

  task automatic inject(input int src, input int tgt, input br_svc_e svc, input int id,
                        input logic [31:0] pay);
    br_data_t f;
    int       n;
    f.payload    = pay;
    f.seq_source = 16'(src);
    f.seq_target = 16'(tgt);
    f.service    = svc;
    f.id         = 5'(id);
    n = 0;
    while (busy_o[src] && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (busy_o[src]) begin
      chk("busy_timeout", busy_o[src], 1'b0);
      return;
    end
    msg_tab[src][id] = f;
    for (int p = 0; p < PE; p++)
      exp_pend[p][src][id] = (svc == BR_SVC_ALL) ? (p != src) : (p == tgt);
    flit_i[src] = f;
    req_i[src]  = 1'b1;
    @(negedge clk);
    chk("ack_rise", ack_o[src], 1'b1);
    req_i[src] = 1'b0;
    @(negedge clk);
    chk("ack_pulse", ack_o[src], 1'b0);
    $display("inject src=%0d tgt=%0d svc=%0d id=%0d payload=%h waited=%0d", src, tgt, svc,
             id, pay, n);
  endtask

  task automatic expect_all(input string tag, input int exp_n, input int base);
    int outst = 0;
    for (int p = 0; p < PE; p++)
      for (int s = 0; s < PE; s++)
        for (int i = 0; i < 32; i++)
          if (exp_pend[p][s][i]) outst++;
    chk({tag, "_missing"}, outst, 0);
    chk({tag, "_count"}, deliv_cnt - base, exp_n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int base;
    for (int p = 0; p < PE; p++) ack_delay[p] = 0;
    flit_i = '0;
    req_i  = '0;
    rst_n  = 1'b0;
    idle(3);
    chk("rst_req_o", req_o, 0);
    chk("rst_ack_o", ack_o, 0);
    chk("rst_busy_o", busy_o, 0);
    chk("rst_flit_o", |flit_o, 0);
    rst_n = 1'b1;
    idle(1);

    // 1: single ALL flood from PE0
    base = deliv_cnt;
    inject(0, 0, BR_SVC_ALL, 0, 32'h0000CAFE);
    idle(100);
    expect_all("s1", 15, base);

    // 2: targeted message, only PE10 may see it
    base = deliv_cnt;
    inject(5, 10, BR_SVC_TGT, 1, 32'h00001234);
    idle(200);
    expect_all("s2", 1, base);
    chk("s2_target_pe", last_pe, 10);

    // 3: simultaneous floods from opposite corners
    base = deliv_cnt;
    fork
      inject(0, 0, BR_SVC_ALL, 2, 32'hAAAA0000);
      inject(15, 0, BR_SVC_ALL, 3, 32'hBBBB0015);
    join
    idle(100);
    expect_all("s3", 30, base);
    idle(300);

    // 4: eight back-to-back injections from PE6; table fills after seven
    base = deliv_cnt;
    for (int k = 0; k < 8; k++) begin
      inject(6, 0, BR_SVC_ALL, k, 32'h66000000 + 32'(k));
      if (k == 6) chk("s4_busy_full", busy_o[6], 1'b1);
    end
    idle(200);
    expect_all("s4", 120, base);
    idle(300);

    // 5: slow PE acknowledgements, then one PE stalling its port for 50 cycles
    for (int p = 0; p < PE; p++) ack_delay[p] = 2;
    base = deliv_cnt;
    inject(9, 0, BR_SVC_ALL, 16, 32'h99990016);
    idle(150);
    expect_all("s5a", 15, base);
    ack_delay[4] = 50;
    base = deliv_cnt;
    for (int k = 17; k < 21; k++) inject(9, 0, BR_SVC_ALL, k, 32'h99990000 + 32'(k));
    idle(500);
    expect_all("s5b", 60, base);
    for (int p = 0; p < PE; p++) ack_delay[p] = 0;

    // 6: reset in the middle of a flood, then a fresh flood
    inject(0, 0, BR_SVC_ALL, 21, 32'h0000DEAD);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_req_o", req_o, 0);
    chk("s6_rst_ack_o", ack_o, 0);
    chk("s6_rst_busy_o", busy_o, 0);
    chk("s6_rst_flit_o", |flit_o, 0);
    for (int p = 0; p < PE; p++)
      for (int s = 0; s < PE; s++)
        for (int i = 0; i < 32; i++) exp_pend[p][s][i] = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    base = deliv_cnt;
    inject(0, 0, BR_SVC_ALL, 0, 32'h0000CAFE);
    idle(100);
    expect_all("s6", 15, base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
